// File: rtl/kv_cache_bank_pkg.sv
// Shared sizing and types for the per-head KV-cache bank.
// Row width is derived from the model geometry so that one row holds one head's K or V slice.
package kv_cache_bank_pkg;

  localparam int N_EMBD      = 256;
  localparam int N_HEAD      = 16;
  localparam int BIT_W       = 8;
  localparam int KV_WORDLINE = N_EMBD / N_HEAD * BIT_W;
  localparam int KV_ADDR_W   = 8;
  localparam int KV_RD_LAT   = 2;

  typedef logic [KV_WORDLINE-1:0] kv_cache_packed_t;

endpackage

// File: rtl/kv_cache_bank_if.sv
// Request/response bundle between the attention-core KV requester and one cache bank.
interface kv_cache_bank_if
  import kv_cache_bank_pkg::*;
#(
  parameter int WORDLINE = KV_WORDLINE,
  parameter int ADDR_W   = KV_ADDR_W
);

  // Handshake: me qualifies a request in the cycle it is high; there is no ready because
  // the bank accepts every request. dout_valid marks the single cycle a read result is
  // presented; the consumer must take it then, as it is never replayed.
  logic [ADDR_W-1:0]   address;
  logic [WORDLINE-1:0] data;
  logic                me;
  logic                we;
  logic                oe;
  logic                clr;
  logic [WORDLINE-1:0] dout;
  logic                dout_valid;
  logic                rd_oob;
  logic [ADDR_W:0]     fill_cnt;

  modport master (
    output address, data, me, we, oe, clr,
    input  dout, dout_valid, rd_oob, fill_cnt
  );

  modport slave (
    input  address, data, me, we, oe, clr,
    output dout, dout_valid, rd_oob, fill_cnt
  );

endinterface

// File: rtl/kv_sram_array.sv
// Single-port row store: synchronous write, one-cycle registered read.
// Kept behind this boundary so a foundry SRAM macro can replace the flop array.
module kv_sram_array
  import kv_cache_bank_pkg::*;
#(
  parameter int WORDLINE = KV_WORDLINE,
  parameter int ADDR_W   = KV_ADDR_W
) (
  input  logic                clk,
  input  logic                me_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [WORDLINE-1:0] wdata_i,
  output logic [WORDLINE-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WORDLINE-1:0] mem_q [DEPTH];
  logic [WORDLINE-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (me_i && we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (me_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/kv_cache_bank.sv
// Per-head KV-cache bank: row store, fixed-latency read pipeline, fill-level tracking
// with out-of-range read flagging, and combinational output gating by oe.
module kv_cache_bank
  import kv_cache_bank_pkg::*;
#(
  parameter int WORDLINE = KV_WORDLINE,
  parameter int ADDR_W   = KV_ADDR_W,
  parameter int RD_LAT   = KV_RD_LAT
) (
  input  logic            clk,
  input  logic            rst_n,
  kv_cache_bank_if.slave  bus
);

  logic wr_req;
  logic rd_req;
  logic oob_at_issue;

  logic [ADDR_W:0] fill_q, fill_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [RD_LAT-1:0] oob_q, oob_d;

  logic [WORDLINE-1:0] sram_rdata;
  logic [WORDLINE-1:0] head_data;

  assign wr_req       = bus.me & bus.we;
  assign rd_req       = bus.me & ~bus.we;
  assign oob_at_issue = {1'b0, bus.address} >= fill_q;

  kv_sram_array #(
    .WORDLINE (WORDLINE),
    .ADDR_W   (ADDR_W)
  ) u_array (
    .clk     (clk),
    .me_i    (bus.me),
    .we_i    (bus.we),
    .addr_i  (bus.address),
    .wdata_i (bus.data),
    .rdata_o (sram_rdata)
  );

  // clr takes priority so a same-cycle write still lands in the array but not in the count.
  always_comb begin
    fill_d = fill_q;
    if (bus.clr) begin
      fill_d = '0;
    end else if (wr_req && oob_at_issue) begin
      fill_d = {1'b0, bus.address} + (ADDR_W+1)'(1);
    end
  end

  always_comb begin
    vld_d    = '0;
    oob_d    = '0;
    vld_d[0] = rd_req;
    oob_d[0] = oob_at_issue;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      oob_d[i] = oob_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= '0;
      vld_q  <= '0;
      oob_q  <= '0;
    end else begin
      fill_q <= fill_d;
      vld_q  <= vld_d;
      oob_q  <= oob_d;
    end
  end

  // The array itself supplies the first stage of data delay; only RD_LAT-1 more are needed.
  if (RD_LAT == 1) begin : g_lat1
    assign head_data = sram_rdata;
  end else begin : g_latn
    logic [WORDLINE-1:0] data_q [RD_LAT-1];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < RD_LAT-1; i++) data_q[i] <= '0;
      end else begin
        data_q[0] <= sram_rdata;
        for (int i = 1; i < RD_LAT-1; i++) data_q[i] <= data_q[i-1];
      end
    end
    assign head_data = data_q[RD_LAT-2];
  end

  always_comb begin
    bus.dout_valid = vld_q[RD_LAT-1] & bus.oe;
    bus.rd_oob     = bus.dout_valid & oob_q[RD_LAT-1];
    bus.dout       = (bus.dout_valid && !oob_q[RD_LAT-1]) ? head_data : '0;
  end

  assign bus.fill_cnt = fill_q;

endmodule

// File: tb/tb_kv_cache_bank.sv
// Bench for kv_cache_bank: directed scenarios plus random traffic against a behavioural model.
module tb_kv_cache_bank;
  import kv_cache_bank_pkg::*;

  localparam int W     = KV_WORDLINE;
  localparam int AW    = KV_ADDR_W;
  localparam int LAT   = KV_RD_LAT;
  localparam int DEPTH = 2 ** AW;

  logic clk;
  logic rst_n;

  kv_cache_bank_if bus ();

  kv_cache_bank dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: array contents, fill level, and what must appear in each future cycle.
  logic [W-1:0] m_mem [DEPTH];
  int           m_fill;
  logic         s_vld [8];
  logic         s_oob [8];
  logic [W-1:0] s_dat [8];
  int           cyc;

  int n_checks;
  int n_fail;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pat(input logic [7:0] b);
    pat = {16{b}};
  endfunction

  function automatic logic [W-1:0] rnd_row();
    rnd_row = {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic clear_sched();
    for (int i = 0; i < 8; i++) begin
      s_vld[i] = 1'b0;
      s_oob[i] = 1'b0;
      s_dat[i] = '0;
    end
  endtask

  // Drive one cycle of inputs, record what a read must present LAT cycles later,
  // then retire the cycle's write/clear effects at the clock edge.
  task automatic step(input bit me, input bit we, input int addr, input logic [W-1:0] d,
                      input bit oe, input bit clr);
    int slot;
    bus.me      = me;
    bus.we      = we;
    bus.address = AW'(addr);
    bus.data    = d;
    bus.oe      = oe;
    bus.clr     = clr;
    slot = (cyc + LAT) % 8;
    if (me && !we && rst_n) begin
      s_vld[slot] = 1'b1;
      s_oob[slot] = (addr >= m_fill);
      s_dat[slot] = (addr >= m_fill) ? '0 : m_mem[addr];
    end else begin
      s_vld[slot] = 1'b0;
      s_oob[slot] = 1'b0;
      s_dat[slot] = '0;
    end
    @(posedge clk);
    if (rst_n) begin
      if (me && we) begin
        m_mem[addr] = d;
        if (addr >= m_fill) m_fill = addr + 1;
      end
      if (clr) m_fill = 0;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input bit oe);
    step(1'b0, 1'b0, 0, '0, oe, 1'b0);
  endtask

  task automatic wr(input int addr, input logic [W-1:0] d);
    step(1'b1, 1'b1, addr, d, 1'b1, 1'b0);
  endtask

  task automatic rd(input int addr);
    step(1'b1, 1'b0, addr, '0, 1'b1, 1'b0);
  endtask

  // Asynchronous reset: anything in flight is forgotten, outputs drop at once.
  task automatic do_reset();
    rst_n = 1'b0;
    clear_sched();
    m_fill = 0;
    #1;
    chk("reset_dout_valid", W'(bus.dout_valid), '0);
    chk("reset_fill_cnt", W'(bus.fill_cnt), '0);
    chk("reset_dout", bus.dout, '0);
    idle(1'b1);
    idle(1'b1);
    #2 rst_n = 1'b1;
    idle(1'b1);
  endtask

  // Per-cycle compare against the model, away from the active edge.
  initial begin
    logic         e_v;
    logic [W-1:0] e_d;
    logic         e_o;
    forever begin
      @(negedge clk);
      e_v = s_vld[cyc % 8] & bus.oe;
      e_o = e_v & s_oob[cyc % 8];
      e_d = e_v ? s_dat[cyc % 8] : '0;
      chk("dout_valid", W'(bus.dout_valid), W'(e_v));
      chk("rd_oob", W'(bus.rd_oob), W'(e_o));
      chk("dout", bus.dout, e_d);
      chk("fill_cnt", W'(bus.fill_cnt), W'(m_fill));
    end
  end

  initial begin
    logic [W-1:0] p5;
    logic [W-1:0] p7;
    n_checks    = 0;
    n_fail      = 0;
    cyc         = 0;
    m_fill      = 0;
    rst_n       = 1'b0;
    bus.me      = 1'b0;
    bus.we      = 1'b0;
    bus.address = '0;
    bus.data    = '0;
    bus.oe      = 1'b1;
    bus.clr     = 1'b0;
    clear_sched();
    idle(1'b1);
    idle(1'b1);
    #2 rst_n = 1'b1;
    idle(1'b1);

    // Give every row a known value; the array survives reset.
    for (int a = 0; a < DEPTH; a++) wr(a, rnd_row());
    chk("prefill_fill_cnt", W'(bus.fill_cnt), W'(256));
    do_reset();

    // Scenario 1: fill four rows, read each back with exactly two cycles of latency.
    wr(0, pat(8'h11));
    wr(1, pat(8'h22));
    wr(2, pat(8'h33));
    wr(3, pat(8'h44));
    chk("s1_fill_cnt", W'(bus.fill_cnt), W'(4));
    for (int a = 0; a < 4; a++) begin
      rd(a);
      chk("s1_not_early", W'(bus.dout_valid), '0);
      idle(1'b1);
      chk("s1_valid_at_lat", W'(bus.dout_valid), W'(1));
      chk("s1_data", bus.dout, pat(8'((a + 1) * 8'h11)));
    end

    // Scenario 2: back-to-back reads come out in order without bubbles.
    rd(3);
    rd(2);
    chk("s2_first", bus.dout, pat(8'h44));
    rd(1);
    chk("s2_second", bus.dout, pat(8'h33));
    rd(0);
    chk("s2_third", bus.dout, pat(8'h22));
    idle(1'b1);
    chk("s2_fourth", bus.dout, pat(8'h11));
    chk("s2_fourth_valid", W'(bus.dout_valid), W'(1));
    idle(1'b1);

    // Scenario 3: read beyond the fill level, then extend the fill past it.
    rd(9);
    idle(1'b1);
    chk("s3_oob_valid", W'(bus.dout_valid), W'(1));
    chk("s3_oob_flag", W'(bus.rd_oob), W'(1));
    chk("s3_oob_data", bus.dout, '0);
    wr(9, rnd_row());
    chk("s3_fill_cnt", W'(bus.fill_cnt), W'(10));

    // Scenario 4: read-after-write, then clr racing a write.
    p5 = rnd_row();
    p7 = rnd_row();
    wr(5, p5);
    rd(5);
    idle(1'b1);
    chk("s4_raw_data", bus.dout, p5);
    step(1'b1, 1'b1, 7, p7, 1'b1, 1'b1);
    chk("s4_clr_fill", W'(bus.fill_cnt), '0);
    rd(7);
    idle(1'b1);
    chk("s4_cleared_oob", W'(bus.rd_oob), W'(1));
    wr(8, rnd_row());
    chk("s4_refill", W'(bus.fill_cnt), W'(9));
    rd(7);
    idle(1'b1);
    chk("s4_clr_write_kept", bus.dout, p7);

    // Scenario 5: a presentation with oe low is dropped, including its oob flag.
    rd(3);
    idle(1'b1);
    idle(1'b0);
    rd(200);
    idle(1'b1);
    bus.oe = 1'b0;
    #1;
    chk("s5_gated_valid", W'(bus.dout_valid), '0);
    chk("s5_gated_oob", W'(bus.rd_oob), '0);
    chk("s5_gated_dout", bus.dout, '0);
    idle(1'b0);
    rd(2);
    idle(1'b1);
    chk("s5_recovered", bus.dout, pat(8'h33));
    idle(1'b1);

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      int  a;
      bit  me;
      bit  we;
      a  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH-1)
                                       : $urandom_range(0, m_fill + 4 > DEPTH-1 ? DEPTH-1 : m_fill + 4);
      me = ($urandom_range(0, 9) < 8);
      we = ($urandom_range(0, 2) == 0);
      step(me, we, a, rnd_row(), ($urandom_range(0, 9) < 8), ($urandom_range(0, 49) == 0));
    end
    idle(1'b1);
    idle(1'b1);

    // Scenario 6: reset with reads in flight, then saturate the fill level.
    rd(0);
    rd(1);
    do_reset();
    idle(1'b1);
    idle(1'b1);
    wr(255, rnd_row());
    chk("s6_saturate", W'(bus.fill_cnt), W'(256));
    wr(255, rnd_row());
    chk("s6_no_overflow", W'(bus.fill_cnt), W'(256));
    rd(255);
    idle(1'b1);
    idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
